// File: rtl/lsu_pkg.sv
// Shared types and alignment helpers for the load/store unit.
// lsu_bad() is only called when LSU_MISALIGN_EXC_EN is defined.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_funct3_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

   function automatic logic is_byte(logic [2:0] f3);
      return (f3 == LSU_B) || (f3 == LSU_BU);
   endfunction

   function automatic logic is_half(logic [2:0] f3);
      return (f3 == LSU_H) || (f3 == LSU_HU);
   endfunction

   // Half accesses use a[1] only; words and illegal codes cover the whole word.
   function automatic logic [3:0] lsu_mask(logic [2:0] f3, logic [1:0] a);
      if (is_byte(f3)) return 4'b0001 << a;
      if (is_half(f3)) return 4'b0011 << {a[1], 1'b0};
      return 4'b1111;
   endfunction

   function automatic logic [31:0] lsu_extract(logic [2:0] f3, logic [1:0] a, logic [31:0] word);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = word >> {a, 3'b000};
      b  = sh[7:0];
      h  = a[1] ? word[31:16] : word[15:0];
      case (f3)
         LSU_B:   return {{24{b[7]}}, b};
         LSU_BU:  return {24'h0, b};
         LSU_H:   return {{16{h[15]}}, h};
         LSU_HU:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic lsu_bad(logic [2:0] f3, logic [1:0] a);
      case (f3)
         LSU_B, LSU_BU: return 1'b0;
         LSU_H, LSU_HU: return a[0];
         LSU_W:         return |a;
         default:       return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, load extraction.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_word,
   output logic [3:0]  mask,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   assign mask      = lsu_mask(funct3, addr_lo);
   assign rdata_ext = lsu_extract(funct3, addr_lo, rdata_word);

   // Replicating narrow data on every lane lets the mask alone select the target bytes.
   always_comb begin
      wdata_lanes = wdata;
      if (is_byte(funct3))      wdata_lanes = {4{wdata[7:0]}};
      else if (is_half(funct3)) wdata_lanes = {2{wdata[15:0]}};
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory, one transaction at a time.
// Define LSU_MISALIGN_EXC_EN to reject misaligned/illegal requests with rsp_err.
//
//  state    | meaning
//  ST_IDLE  | req_ready high, capture request on req_valid
//  ST_ISSUE | one-cycle mem_request from captured regs
//  ST_WAIT  | load data on mem_data_out, register extracted value
//  ST_RESP  | rsp_valid high until rsp_ready
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int Address   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [DataWidth-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataWidth-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 mem_request,
   output logic                 mem_we_re,
   output logic [3:0]           mem_mask,
   output logic [Address-1:0]   mem_address,
   output logic [DataWidth-1:0] mem_data_in,
   input  logic [DataWidth-1:0] mem_data_out
);

   lsu_state_e           state_q, state_d;
   logic                 we_q;
   logic [2:0]           funct3_q;
   logic [Address+1:0]   addr_q;
   logic [DataWidth-1:0] wdata_q;
   logic [3:0]           mask_w;
   logic [31:0]          wdata_lanes;
   logic [31:0]          rdata_ext;
   logic                 accept;
   logic                 bad_req;
   logic                 unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:Address+2];
   assign accept         = (state_q == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_EXC_EN
   assign bad_req = lsu_bad(req_funct3, req_addr[1:0]);
`else
   assign bad_req = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      mem_request = 1'b0;
      rsp_valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = bad_req ? ST_RESP : ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_request = 1'b1;
            state_d     = we_q ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // rsp_rdata is cleared on accept so stores and rejected requests answer 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         we_q      <= req_we;
         funct3_q  <= req_funct3;
         addr_q    <= req_addr[Address+1:0];
         wdata_q   <= req_wdata;
         rsp_rdata <= '0;
         rsp_err   <= bad_req;
      end else if (state_q == ST_WAIT) begin
         rsp_rdata <= rdata_ext;
      end
   end

   lsu_align u_align (
      .funct3      (funct3_q),
      .addr_lo     (addr_q[1:0]),
      .wdata       (wdata_q),
      .rdata_word  (mem_data_out),
      .mask        (mask_w),
      .wdata_lanes (wdata_lanes),
      .rdata_ext   (rdata_ext)
   );

   assign mem_we_re   = we_q;
   assign mem_mask    = mem_request ? mask_w : 4'b0000;
   assign mem_address = addr_q[Address+1:2];
   assign mem_data_in = wdata_lanes;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases, reset abort, randomized traffic.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_request, mem_we_re;
   logic [3:0]  mem_mask;
   logic [7:0]  mem_address;
   logic [31:0] mem_data_in, mem_data_out;

   always #5 clk = ~clk;

   load_store_unit #(.DataWidth(32), .Address(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;
   typedef struct packed {logic we; logic [3:0] mask; logic [7:0] addr; logic [31:0] data;} memx_t;

   rsp_t        exp_rsp[$];
   memx_t       exp_mem[$];
   logic [31:0] ref_mem [256];
   logic [31:0] mem_arr [256];
   logic        mem_init;
   int          errors = 0;
   int          checks = 0;
   rsp_t        mr;
   memx_t       mm;

   function automatic logic [31:0] init_word(int i);
      if (i == 4) return 32'h80FF7F01;
      return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Memory environment: registered read, byte-masked write.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      end else if (mem_request) begin
         if (mem_we_re) begin
            for (int b = 0; b < 4; b++)
               if (mem_mask[b]) mem_arr[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
         end else begin
            mem_data_out <= mem_arr[mem_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: size/offset arithmetic over a byte view of memory.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] exp_rd);
      int          size, off;
      logic        sgn, bad;
      logic [7:0]  wa;
      logic [63:0] v;
      memx_t       m;
      rsp_t        r;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      sgn  = (f3 == 3'd0 || f3 == 3'd1);
`ifdef LSU_MISALIGN_EXC_EN
      bad  = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (size == 2 && addr[0]) ||
             (size == 4 && addr[1:0] != 2'b00);
`else
      bad  = 1'b0;
`endif
      off  = (size == 1) ? int'(addr[1:0]) : (size == 2) ? 2 * int'(addr[1]) : 0;
      wa   = addr[9:2];
      r.err   = bad;
      r.rdata = 32'h0;
      if (bad) begin
         lat = 1;
      end else begin
         m.we   = we;
         m.mask = 4'((1 << size) - 1) << off;
         m.addr = wa;
         m.data = (size == 1) ? wd[7:0] * 32'h01010101 :
                  (size == 2) ? wd[15:0] * 32'h00010001 : wd;
         exp_mem.push_back(m);
         if (we) begin
            for (int i = 0; i < size; i++) ref_mem[wa][8*(off+i) +: 8] = wd[8*i +: 8];
            lat = 2;
         end else begin
            v = 64'(ref_mem[wa] >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
            if (sgn && v[8*size-1]) v = v - (64'd1 << (8 * size));
            r.rdata = v[31:0];
            lat = 3;
         end
      end
      exp_rsp.push_back(r);
      exp_rd = r.rdata;
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got response %h with empty scoreboard", rsp_rdata);
         end else begin
            mr = exp_rsp.pop_front();
            chk("rsp_rdata", rsp_rdata, mr.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(mr.err));
         end
      end
      if (rst_n && mem_request) begin
         if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: got request addr %h with empty scoreboard", mem_address);
         end else begin
            mm = exp_mem.pop_front();
            chk("mem_we_re", 32'(mem_we_re), 32'(mm.we));
            chk("mem_mask", 32'(mem_mask), 32'(mm.mask));
            chk("mem_address", 32'(mem_address), 32'(mm.addr));
            if (mm.we) chk("mem_data_in", mem_data_in, mm.data);
         end
      end else if (rst_n) begin
         chk("mem_mask_idle", 32'(mem_mask), 32'h0);
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input logic early,
                         output logic [31:0] got_rd, output logic got_req,
                         output logic [3:0] got_mask, output logic [7:0] got_addr,
                         output logic [31:0] got_din);
      int          lat, n;
      logic [31:0] erd;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("req_ready_idle", 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      model(we, f3, addr, wd, lat, erd);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      got_req = mem_request; got_mask = mem_mask; got_addr = mem_address; got_din = mem_data_in;
      chk("req_ready_busy", 32'(req_ready), 32'h0);
      if (early) rsp_ready = 1'b1;
      n = 1;
      while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("latency", 32'(n), 32'(lat));
      chk("rdata_first", rsp_rdata, erd);
      got_rd = rsp_rdata;
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rdata", rsp_rdata, erd);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, din;
      logic        rq;
      logic [3:0]  mk;
      logic [7:0]  ad;
      logic [2:0]  f3;
      int          lat;
      logic [31:0] erd;
      logic [2:0]  legal [5];
      legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      rsp_ready = 1'b0; rst_n = 1'b0; mem_init = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_rsp_err", 32'(rsp_err), 32'h0);
      chk("reset_mem_request", 32'(mem_request), 32'h0);
      chk("reset_req_ready", 32'(req_ready), 32'h1);
      mem_init = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_req(1'b0, 3'd0, 32'h13, 32'h0, 5, 1'b0, rd, rq, mk, ad, din);
      chk("lb_0x13", rd, 32'hFFFFFF80);
      do_req(1'b0, 3'd4, 32'h11, 32'h0, 0, 1'b0, rd, rq, mk, ad, din);
      chk("lbu_0x11", rd, 32'h0000007F);
      do_req(1'b0, 3'd1, 32'h12, 32'h0, 1, 1'b1, rd, rq, mk, ad, din);
      chk("lh_0x12", rd, 32'hFFFF80FF);
      do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, rq, mk, ad, din);
      chk("sw_mask", 32'(mk), 32'hF);
      chk("sw_addr", 32'(ad), 32'h04);
      chk("sw_din", din, 32'hDEADBEEF);
      do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, 2, 1'b0, rd, rq, mk, ad, din);
      chk("sb_mask", 32'(mk), 32'h8);
      chk("sb_din", din, 32'hA5A5A5A5);
      chk("sb_rdata_zero", rd, 32'h0);
      do_req(1'b0, 3'd2, 32'h06, 32'h0, 0, 1'b0, rd, rq, mk, ad, din);
`ifdef LSU_MISALIGN_EXC_EN
      chk("lw_mis_no_request", 32'(rq), 32'h0);
`else
      chk("lw_mis_addr", 32'(ad), 32'h01);
      chk("lw_mis_rdata", rd, init_word(1));
`endif

      // Reset abort: once mid-ISSUE, once mid-WAIT, then a normal request.
      for (int k = 0; k < 2; k++) begin
         req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h0;
         model(1'b0, 3'd2, 32'h20, 32'h0, lat, erd);
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (k == 0) chk("abort_issue_req", 32'(mem_request), 32'h1);
         else begin @(posedge clk); #1; end
         #1 rst_n = 1'b0;
         #1;
         chk("abort_mem_request", 32'(mem_request), 32'h0);
         chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("abort_req_ready", 32'(req_ready), 32'h1);
         exp_rsp.delete();
         exp_mem.delete();
         @(posedge clk); #1 rst_n = 1'b1;
         do_req(1'b0, 3'd5, 32'h12, 32'h0, 0, 1'b0, rd, rq, mk, ad, din);
      end

      for (int t = 0; t < 200; t++) begin
         f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         do_req(1'($urandom_range(0, 1)), f3,
                ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                rd, rq, mk, ad, din);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'h0);
      chk("mem_queue_empty", 32'(exp_mem.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
